// File: rtl/prs_density_decoder.sv
// Density-stream decoder: counts ones over 2**WIDTH enabled samples.
// Optional macro PRSDEC_SYNC_EN adds a 2-flop input synchronizer.
module prs_density_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in,
    output logic [WIDTH-1:0] value,
    output logic             valid,
    output logic             sat
);

    logic en_s;
    logic in_s;

`ifdef PRSDEC_SYNC_EN
    logic [1:0] in_sync_q, in_sync_d;
    logic [1:0] en_sync_q, en_sync_d;

    // en rides the same two stages so each sample keeps its enable
    always_comb begin
        in_sync_d = {in_sync_q[0], in};
        en_sync_d = {en_sync_q[0], en};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_sync_q <= '0;
            en_sync_q <= '0;
        end else begin
            in_sync_q <= in_sync_d;
            en_sync_q <= en_sync_d;
        end
    end

    assign in_s = in_sync_q[1];
    assign en_s = en_sync_q[1];
`else
    assign in_s = in;
    assign en_s = en;
`endif

    logic [WIDTH-1:0] wcnt_q, wcnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             valid_q, valid_d;
    logic             sat_q, sat_d;
    logic [WIDTH:0]   sum;
    logic             last;

    always_comb begin
        sum     = acc_q + {{WIDTH{1'b0}}, in_s};
        last    = &wcnt_q;
        wcnt_d  = wcnt_q;
        acc_d   = acc_q;
        value_d = value_q;
        sat_d   = sat_q;
        valid_d = 1'b0;
        if (en_s) begin
            if (last) begin
                // a full window of ones would need WIDTH+1 bits; clip it
                value_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
                sat_d   = sum[WIDTH];
                valid_d = 1'b1;
                acc_d   = '0;
                wcnt_d  = '0;
            end else begin
                acc_d  = sum;
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_q  <= '0;
            acc_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
        end
    end

    assign value = value_q;
    assign valid = valid_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_prs_density_decoder.sv
// Directed bench for prs_density_decoder (WIDTH=8).
// Define PRSDEC_SYNC_EN for both files to check the synchronized build.
module tb_prs_density_decoder;

`ifdef PRSDEC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic [7:0] value;
    logic       valid;
    logic       sat;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int vcount = 0;
    int vcyc = 0;
    int vcyc_prev = 0;
    int dbl = 0;
    int chg = 0;
    logic [7:0] cap_value = 8'h00;
    logic       cap_sat = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] last_value = 8'h00;
    logic       last_sat = 1'b0;

    prs_density_decoder #(.WIDTH(8)) dut (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .in   (din),
        .value(value),
        .valid(valid),
        .sat  (sat)
    );

    always #5 clk = ~clk;

    // one clock with the given inputs; records what the DUT shows after the edge
    task automatic step(input logic e, input logic i);
        en  = e;
        din = i;
        @(posedge clk);
        #1;
        cyc++;
        if (valid === 1'b1) begin
            vcount++;
            vcyc_prev = vcyc;
            vcyc = cyc;
            cap_value = value;
            cap_sat = sat;
            if (prev_valid) dbl++;
        end else if (value !== last_value || sat !== last_sat) begin
            chg++;
        end
        prev_valid = valid;
        last_value = value;
        last_sat = sat;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        en = 1'b0;
        din = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (value !== 8'h00) begin
            bad++;
            $display("FAIL reset_value got=%h want=00", value);
        end
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b want=0", valid);
        end
        total++;
        if (sat !== 1'b0) begin
            bad++;
            $display("FAIL reset_sat got=%b want=0", sat);
        end
        reset = 1'b1;
        prev_valid = 1'b0;
        last_value = 8'h00;
        last_sat = 1'b0;
    endtask

    task automatic test_zeros;
        int start;
        int v0;
        start = cyc;
        v0 = vcount;
        for (int k = 0; k < 256; k++) step(1'b1, 1'b0);
        idle(LAT);
        total++;
        if (vcount - v0 !== 1) begin
            bad++;
            $display("FAIL zeros_count got=%0d want=1", vcount - v0);
        end
        total++;
        if (vcyc !== start + 256 + LAT) begin
            bad++;
            $display("FAIL zeros_latency got=%0d want=%0d", vcyc - start, 256 + LAT);
        end
        total++;
        if (cap_value !== 8'h00 || cap_sat !== 1'b0) begin
            bad++;
            $display("FAIL zeros_value got=%h/%b want=00/0", cap_value, cap_sat);
        end
        idle(1);
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL zeros_pulse got=%b want=0", valid);
        end
    endtask

    task automatic test_ones;
        for (int k = 0; k < 256; k++) step(1'b1, 1'b1);
        idle(LAT);
        total++;
        if (cap_value !== 8'hFF || cap_sat !== 1'b1) begin
            bad++;
            $display("FAIL ones_value got=%h/%b want=ff/1", cap_value, cap_sat);
        end
        for (int k = 0; k < 128; k++) step(1'b1, 1'b0);
        total++;
        if (value !== 8'hFF || sat !== 1'b1) begin
            bad++;
            $display("FAIL ones_hold got=%h/%b want=ff/1", value, sat);
        end
        for (int k = 0; k < 128; k++) step(1'b1, 1'b0);
        idle(LAT);
        total++;
        if (cap_value !== 8'h00 || cap_sat !== 1'b0) begin
            bad++;
            $display("FAIL ones_clear got=%h/%b want=00/0", cap_value, cap_sat);
        end
    endtask

    task automatic test_alternating;
        int v0;
        v0 = vcount;
        for (int k = 0; k < 512; k++) step(1'b1, (k % 2 == 0) ? 1'b1 : 1'b0);
        idle(LAT);
        total++;
        if (cap_value !== 8'h80 || cap_sat !== 1'b0) begin
            bad++;
            $display("FAIL alt_value got=%h/%b want=80/0", cap_value, cap_sat);
        end
        total++;
        if (vcount - v0 !== 2 || vcyc - vcyc_prev !== 256) begin
            bad++;
            $display("FAIL alt_period got=%0d/%0d want=2/256",
                     vcount - v0, vcyc - vcyc_prev);
        end
    endtask

    task automatic test_gap;
        int start;
        start = cyc;
        for (int k = 0; k < 100; k++) step(1'b1, (k % 2 == 0) ? 1'b1 : 1'b0);
        idle(37);
        for (int k = 100; k < 256; k++) step(1'b1, (k % 2 == 0) ? 1'b1 : 1'b0);
        idle(LAT);
        total++;
        if (cap_value !== 8'h80) begin
            bad++;
            $display("FAIL gap_value got=%h want=80", cap_value);
        end
        total++;
        if (vcyc !== start + 256 + 37 + LAT) begin
            bad++;
            $display("FAIL gap_latency got=%0d want=%0d", vcyc - start, 293 + LAT);
        end
    endtask

    task automatic test_boundary;
        for (int k = 0; k < 256; k++) step(1'b1, (k == 255) ? 1'b0 : 1'b1);
        idle(LAT);
        total++;
        if (cap_value !== 8'hFF || cap_sat !== 1'b0) begin
            bad++;
            $display("FAIL bound_255 got=%h/%b want=ff/0", cap_value, cap_sat);
        end
        for (int k = 0; k < 256; k++) step(1'b1, (k == 17) ? 1'b1 : 1'b0);
        idle(LAT);
        total++;
        if (cap_value !== 8'h01 || cap_sat !== 1'b0) begin
            bad++;
            $display("FAIL bound_1 got=%h/%b want=01/0", cap_value, cap_sat);
        end
    endtask

    task automatic test_reset_mid;
        int v0;
        int vr;
        for (int k = 0; k < 150; k++) step(1'b1, 1'b1);
        reset = 1'b0;
        vr = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (valid !== 1'b0) vr++;
        end
        total++;
        if (vr !== 0 || value !== 8'h00) begin
            bad++;
            $display("FAIL rst_mid_hold got=%0d/%h want=0/00", vr, value);
        end
        reset = 1'b1;
        prev_valid = 1'b0;
        last_value = value;
        last_sat = sat;
        v0 = vcount;
        for (int k = 0; k < 256; k++) step(1'b1, 1'b1);
        idle(LAT);
        total++;
        if (vcount - v0 !== 1 || cap_value !== 8'hFF || cap_sat !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_window got=%0d/%h/%b want=1/ff/1",
                     vcount - v0, cap_value, cap_sat);
        end
    endtask

    task automatic test_prs_loop;
        logic [7:0] lfsr;
        logic       b;
        int ones;
        int seen;
        int q[$];
        int exp_v;
        lfsr = 8'h01;
        ones = 0;
        seen = vcount;
        for (int k = 0; k < 1024 + LAT; k++) begin
            b = (k < 1024) && (lfsr < 8'h80);
            step(k < 1024, b);
            if (k < 1024) begin
                ones += int'(b);
                if (k % 256 == 255) begin
                    q.push_back(ones);
                    ones = 0;
                end
                lfsr = lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);
            end
            if (vcount != seen) begin
                seen = vcount;
                exp_v = (q.size() > 0) ? q.pop_front() : -1;
                total++;
                if (int'(cap_value) !== exp_v || cap_value < 8'h7F || cap_value > 8'h81) begin
                    bad++;
                    $display("FAIL prs_value got=%h want=%0d (0x80+/-1)", cap_value, exp_v);
                end
            end
        end
        total++;
        if (q.size() !== 0) begin
            bad++;
            $display("FAIL prs_windows got=%0d missing want=0", q.size());
        end
    endtask

    task automatic test_back_to_back;
        total++;
        if (dbl !== 0) begin
            bad++;
            $display("FAIL b2b_valid got=%0d want=0", dbl);
        end
        total++;
        if (chg !== 0) begin
            bad++;
            $display("FAIL b2b_quiet_change got=%0d want=0", chg);
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_zeros();
        test_ones();
        test_alternating();
        test_gap();
        test_boundary();
        test_reset_mid();
        test_prs_loop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
